mem_access_unit: RTL and testbench

Load/store front end that sits directly upstream of the word-wide synchronous `RAM` block and drives its `write_enable`, `address` and `data` ports from CPU memory requests. It converts byte-addressed byte, halfword and word accesses into word RAM cycles. It performs read-modify-write for sub-word stores, because the RAM has only a whole-word write enable, and it sign- or zero-extends load data. It presents a valid/ready request port and a one-cycle response pulse to the core.

---
 rtl/mem_access_if.sv | 24 ++
 rtl/mem_access_unit.sv | 216 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// CPU-side request/response bundle of the load/store front end.
// The master drives requests and the slave (mem_access_unit) answers with a one-cycle response.
interface mem_access_if #(parameter int DEPTH = 10);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [DEPTH+1:0] req_addr;
    logic [31:0]      req_wdata;
    logic             resp_valid;
    logic [31:0]      resp_rdata;
    logic             resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front end for a word-wide synchronous RAM (read-modify-write for sub-word stores).
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses respond with resp_err instead of being aligned down.
module mem_access_unit #(
    parameter int DEPTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_if.slave       bus,
    output logic              ram_we,
    output logic [DEPTH-1:0]  ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_RD   = 3'd1,
        S_LD_DATA = 3'd2,
        S_ST_WR   = 3'd3,
        S_RMW_RD  = 3'd4,
        S_RMW_WR  = 3'd5
`ifdef MISALIGN_TRAP_EN
        , S_ERR   = 3'd6
`endif
    } state_t;

    state_t           state_q, state_d;
    logic             ram_we_q, ram_we_d;
    logic [DEPTH-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]      ram_wdata_q, ram_wdata_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic [1:0]       size_q, size_d;
    logic [1:0]       lane_q, lane_d;
    logic             uns_q, uns_d;
    logic [15:0]      wdata_q, wdata_d;
`ifdef MISALIGN_TRAP_EN
    logic             resp_err_q, resp_err_d;
    logic             misalign_s;
`endif

    logic             is_word_s;
    logic             is_half_s;
    logic [1:0]       lane_in_s;
    logic [31:0]      merged_s;

    // Select the addressed lane of a RAM word and sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b00:   res = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   res = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the target byte or halfword lane of a RAM word with right-aligned store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic [15:0] wd);
        logic [31:0] res;
        res = word;
        case (size)
            2'b00:   res[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01:   res[{lane[1], 4'b0000} +: 16] = wd;
            default: res = word;
        endcase
        return res;
    endfunction

    // Decode request size, resolve the byte lane and (trap build) detect misalignment.
    always_comb begin
        is_word_s = bus.req_size[1];
        is_half_s = (bus.req_size == 2'b01);
        if (is_word_s) begin
            lane_in_s = 2'b00;
        end else if (is_half_s) begin
            lane_in_s = {bus.req_addr[1], 1'b0};
        end else begin
            lane_in_s = bus.req_addr[1:0];
        end
`ifdef MISALIGN_TRAP_EN
        misalign_s = (is_half_s && bus.req_addr[0]) || (is_word_s && (bus.req_addr[1:0] != 2'b00));
`endif
    end

    assign merged_s = store_merge(ram_rdata, lane_q, size_q, wdata_q);

    // Next-state and next-output logic of the access sequencer.
    always_comb begin
        state_d      = state_q;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        size_d       = size_q;
        lane_d       = lane_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
`ifdef MISALIGN_TRAP_EN
        resp_err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    ram_addr_d = bus.req_addr[DEPTH+1:2];
                    size_d     = bus.req_size;
                    lane_d     = lane_in_s;
                    uns_d      = bus.req_unsigned;
                    wdata_d    = bus.req_wdata[15:0];
`ifdef MISALIGN_TRAP_EN
                    if (misalign_s) begin
                        state_d = S_ERR;
                    end else
`endif
                    if (!bus.req_we) begin
                        state_d = S_LD_RD;
                    end else if (is_word_s) begin
                        state_d     = S_ST_WR;
                        ram_we_d    = 1'b1;
                        ram_wdata_d = bus.req_wdata;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LD_RD: begin
                state_d = S_LD_DATA;
            end
            S_LD_DATA: begin
                resp_rdata_d = load_extend(ram_rdata, lane_q, size_q, uns_q);
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_ST_WR: begin
                resp_rdata_d = 32'h0000_0000;
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_RMW_RD: begin
                ram_we_d = 1'b1;
                state_d  = S_RMW_WR;
            end
            S_RMW_WR: begin
                ram_wdata_d  = merged_s;
                resp_rdata_d = 32'h0000_0000;
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
`ifdef MISALIGN_TRAP_EN
            S_ERR: begin
                resp_rdata_d = 32'h0000_0000;
                resp_err_d   = 1'b1;
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops ram_we at once so an in-flight RMW never writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            uns_q        <= 1'b0;
            wdata_q      <= 16'h0000;
`ifdef MISALIGN_TRAP_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            size_q       <= size_d;
            lane_q       <= lane_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
`ifdef MISALIGN_TRAP_EN
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    // The RAM output is only valid (and held) during RMW_WR, so the merged word bypasses the register there.
    assign ram_wdata      = (state_q == S_RMW_WR) ? merged_s : ram_wdata_q;
    assign ram_we         = ram_we_q;
    assign ram_addr       = ram_addr_q;
    assign bus.req_ready  = (state_q == S_IDLE) && rst_n;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
`ifdef MISALIGN_TRAP_EN
    assign bus.resp_err   = resp_err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word RAM; expectations follow MISALIGN_TRAP_EN.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    mem_access_if #(.DEPTH(10)) bus ();

    mem_access_unit #(.DEPTH(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-wide synchronous RAM: data_out holds while writing.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we_at;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [11:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err, input int lat, input int we_at);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat; v.we_at = we_at;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [11:0] addr, input logic [31:0] wdata);
        bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    endtask

    task automatic wait_ready(input string name, output bit ok);
        for (int k = 0; k < 10 && !bus.req_ready; k++) begin
            @(posedge clk); #1;
        end
        ok = bus.req_ready;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s ready_timeout actual=0 required=1", name);
        end
    endtask

    // One transaction: accept, then time the response and record when ram_we was high.
    task automatic run_vec(input vec_t v, input int idx);
        int  lat;
        int  wec;
        int  we_at;
        bit  got;
        bit  ok;
        string nm;
        nm = $sformatf("vec%0d", idx);
        drive_req(v.we, v.size, v.uns, v.addr, v.wdata);
        wait_ready(nm, ok);
        if (!ok) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wec = 0; we_at = -1; got = 1'b0; lat = 0;
        if (ram_we) begin wec++; we_at = 0; end
        for (int k = 1; k <= 8 && !got; k++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) begin
                got = 1'b1; lat = k;
            end else if (ram_we) begin
                wec++;
                if (we_at < 0) we_at = k;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s resp_timeout actual=0 required=1", nm);
            return;
        end
        chk({nm, "_rdata"}, bus.resp_rdata, v.rdata);
        chk({nm, "_err"}, {31'd0, bus.resp_err}, {31'd0, v.err});
        chk({nm, "_lat"}, lat, v.lat);
        chk({nm, "_we_cnt"}, wec, (v.we_at >= 0) ? 32'd1 : 32'd0);
        chk({nm, "_we_at"}, we_at, v.we_at);
    endtask

    initial begin
        bit ok;
        int seen;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 12'h000; bus.req_wdata = 32'h0000_0000;

        // we, size, uns, addr, wdata, exp rdata, exp err, latency, cycle of ram_we (-1 none)
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 1, 0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 12'h010, 32'h00000000, 32'hDEADBEEF, 1'b0, 2, -1));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 12'h020, 32'h11223344, 32'h00000000, 1'b0, 1, 0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 12'h022, 32'hFFFFFFAA, 32'h00000000, 1'b0, 2, 1));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 12'h020, 32'h00000000, 32'h11AA3344, 1'b0, 2, -1));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 12'h030, 32'h80FF7F01, 32'h00000000, 1'b0, 1, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 12'h033, 32'h00000000, 32'hFFFFFF80, 1'b0, 2, -1));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 12'h032, 32'h00000000, 32'hFFFFFFFF, 1'b0, 2, -1));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 12'h032, 32'h00000000, 32'h000080FF, 1'b0, 2, -1));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 12'h030, 32'h00000000, 32'h00007F01, 1'b0, 2, -1));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 12'h033, 32'h00000000, 32'h00000080, 1'b0, 2, -1));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 12'h022, 32'h1234BEEF, 32'h00000000, 1'b0, 2, 1));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 12'h020, 32'h00000000, 32'hBEEF3344, 1'b0, 2, -1));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 12'h021, 32'h00000000, 32'h00000033, 1'b0, 2, -1));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 12'h040, 32'hCAFEF00D, 32'h00000000, 1'b0, 1, 0));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 12'h041, 32'h00000000, 32'h00000000, 1'b1, 1, -1));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 12'h031, 32'h00000000, 32'h00000000, 1'b1, 1, -1));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 12'h041, 32'h0000ABCD, 32'h00000000, 1'b1, 1, -1));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 12'h040, 32'h00000000, 32'hCAFEF00D, 1'b0, 2, -1));
`else
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 12'h041, 32'h00000000, 32'hCAFEF00D, 1'b0, 2, -1));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 12'h031, 32'h00000000, 32'h00007F01, 1'b0, 2, -1));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 12'h041, 32'h0000ABCD, 32'h00000000, 1'b0, 2, 1));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 12'h040, 32'h00000000, 32'hCAFEABCD, 1'b0, 2, -1));
`endif
        vecs.push_back(mk(1'b1, 2'b11, 1'b0, 12'h050, 32'h55555555, 32'h00000000, 1'b0, 1, 0));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_addr", {22'd0, ram_addr}, 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset during RMW_WR of a byte store to 0x050 (holding 0x55555555)
        drive_req(1'b1, 2'b00, 1'b0, 12'h050, 32'h000000AA);
        wait_ready("abort", ok);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("abort_rmw_rd_we", {31'd0, ram_we}, 32'd0);
        @(posedge clk); #1;
        chk("abort_rmw_wr_we", {31'd0, ram_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_we_async", {31'd0, ram_we}, 32'd0);
        chk("abort_ready_in_rst", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) seen++;
        end
        chk("abort_no_resp", seen, 32'd0);
        chk("abort_ready_after", {31'd0, bus.req_ready}, 32'd1);
        run_vec(mk(1'b0, 2'b10, 1'b0, 12'h050, 32'h0, 32'h55555555, 1'b0, 2, -1), 100);

        // Back-to-back: word store with a load queued behind it
        drive_req(1'b1, 2'b10, 1'b0, 12'h060, 32'h13572468);
        wait_ready("b2b", ok);
        @(posedge clk); #1;
        bus.req_we = 1'b0; bus.req_wdata = 32'h0;
        chk("b2b_busy", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_st_resp", {31'd0, bus.resp_valid}, 32'd1);
        chk("b2b_ready_with_resp", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("b2b_ld_accepted", {31'd0, bus.req_ready}, 32'd0);
        chk("b2b_resp_pulse", {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b_ld_resp", {31'd0, bus.resp_valid}, 32'd1);
        chk("b2b_ld_rdata", bus.resp_rdata, 32'h13572468);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
